rd_alu: RTL and testbench

64-bit integer ALU for the RV datapath execute stage. Performs add, subtract, bitwise logic and shifts on two operands, with zero/carry/overflow/negative status flags. Result and flags are registered: one clock of latency, synchronous active-high reset. Consumed by writeback and branch-compare logic.

---
 rtl/rd_alu.sv | 94 +++++++++
 tb/tb_rd_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rd_alu.sv
// Registered 64-bit ALU: add/sub/logic/shift with zero/carry/overflow/negative flags.
// One cycle of latency, one op per cycle, no handshake and no backpressure.
module rd_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       op_in,
  output logic [WIDTH-1:0] C_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             negative_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  logic [WIDTH-1:0]        c_d, c_q;
  logic                    zero_d, zero_q;
  logic                    carry_d, carry_q;
  logic                    overflow_d, overflow_q;
  logic                    negative_d, negative_q;

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          diff;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] a_signed;

  always_comb begin
    sum        = {1'b0, A_in} + {1'b0, B_in};
    // Subtract as A + ~B + 1 so the carry-out doubles as the no-borrow flag.
    diff       = {1'b0, A_in} + {1'b0, ~B_in} + {{WIDTH{1'b0}}, 1'b1};
    shamt      = B_in[SHW-1:0];
    a_signed   = A_in;
    c_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_in)
      OP_ADD: begin
        c_d        = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (sum[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        c_d        = diff[WIDTH-1:0];
        carry_d    = diff[WIDTH];
        overflow_d = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (diff[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_AND:  c_d = A_in & B_in;
      OP_OR:   c_d = A_in | B_in;
      OP_XOR:  c_d = A_in ^ B_in;
      OP_SLL:  c_d = A_in << shamt;
      OP_SRL:  c_d = A_in >> shamt;
      OP_SRA:  c_d = a_signed >>> shamt;
      default: c_d = '0;
    endcase
    zero_d     = (c_d == '0);
    negative_d = c_d[WIDTH-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      c_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      c_q        <= c_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end

  assign C_o        = c_q;
  assign zero_o     = zero_q;
  assign carry_o    = carry_q;
  assign overflow_o = overflow_q;
  assign negative_o = negative_q;

endmodule

// File: tb/tb_rd_alu.sv
// Bench for rd_alu: directed and random ops compared against an arithmetic reference model.
module tb_rd_alu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [63:0] A_in, B_in;
  logic [3:0]  op_in;
  logic [63:0] C_o;
  logic        zero_o, carry_o, overflow_o, negative_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [63:0] c;
    logic        z;
    logic        cy;
    logic        ov;
    logic        n;
  } res_t;

  res_t prev;
  logic have_prev = 1'b0;

  rd_alu #(.WIDTH(64)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .A_in       (A_in),
    .B_in       (B_in),
    .op_in      (op_in),
    .C_o        (C_o),
    .zero_o     (zero_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o),
    .negative_o (negative_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic signed [65:0] sext(input logic [63:0] v);
    return $signed({{2{v[63]}}, v});
  endfunction

  // Overflow: the exact signed result does not fit in 64 bits.
  function automatic res_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic [64:0] w;
    logic signed [65:0] exact;
    logic [63:0] all1;
    int s;
    r = '0;
    all1 = '1;
    s = int'(b[5:0]);
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r.c = w[63:0];
        r.cy = w[64];
        exact = sext(a) + sext(b);
        r.ov = (exact != sext(r.c));
      end
      4'd1: begin
        r.c = a - b;
        r.cy = (a >= b);
        exact = sext(a) - sext(b);
        r.ov = (exact != sext(r.c));
      end
      4'd2: r.c = a & b;
      4'd3: r.c = a | b;
      4'd4: r.c = a ^ b;
      4'd5: r.c = a << s;
      4'd6: r.c = a >> s;
      4'd7: r.c = (a >> s) | (a[63] ? ~(all1 >> s) : 64'd0);
      default: r.c = 64'd0;
    endcase
    r.z = (r.c == 64'd0);
    r.n = r.c[63];
    return r;
  endfunction

  task automatic check_outputs(input string tag, input res_t exp);
    chk({tag, "_C"}, C_o, exp.c);
    chk({tag, "_flags"}, {60'd0, zero_o, carry_o, overflow_o, negative_o},
        {60'd0, exp.z, exp.cy, exp.ov, exp.n});
  endtask

  // Called #1 after an edge: apply operands, confirm outputs still hold, then check next edge.
  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    res_t exp;
    op_in = op;
    A_in  = a;
    B_in  = b;
    #1;
    if (have_prev) chk({tag, "_hold"}, C_o, prev.c);
    @(posedge clk_in);
    #1;
    exp = model(op, a, b);
    check_outputs(tag, exp);
    prev = exp;
    have_prev = 1'b1;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    rst_in = 1'b1;
    A_in   = 64'd0;
    B_in   = 64'd0;
    op_in  = 4'd0;
    repeat (2) @(posedge clk_in);
    #1;
    check_outputs("reset", '0);
    rst_in = 1'b0;

    run("add", 4'd0, 64'h10, 64'h20);
    chk("add_const", C_o, 64'h30);
    run("sub", 4'd1, 64'h20, 64'h10);
    chk("sub_carry", {63'd0, carry_o}, 64'd1);
    run("and", 4'd2, 64'h0F0F0F0F0F0F0F0F, 64'h00FF00FF00FF00FF);
    chk("and_const", C_o, 64'h000F000F000F000F);
    run("or",  4'd3, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0);
    run("xor", 4'd4, 64'h0F0F0F0F0F0F0F0F, 64'hFF00FF00FF00FF00);
    chk("xor_const", C_o, 64'hF00FF00FF00FF00F);
    run("sll", 4'd5, 64'd1, 64'd5);
    run("srl", 4'd6, 64'h8000000000000000, 64'h1F);
    chk("srl_const", C_o, 64'h0000000100000000);
    run("sra", 4'd7, 64'h8000000000000000, 64'h3F);
    chk("sra_const", C_o, 64'hFFFFFFFFFFFFFFFF);
    run("sll_wrap", 4'd5, 64'd1, 64'h45);
    chk("sll_wrap_const", C_o, 64'h20);
    run("sra0", 4'd7, 64'h8000000000000001, 64'h40);
    run("add_zero", 4'd0, 64'd0, 64'd0);
    run("add_cy", 4'd0, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    chk("add_cy_const", {61'd0, carry_o, zero_o, overflow_o}, 64'b110);
    run("add_ov", 4'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1);
    chk("add_ov_const", {62'd0, overflow_o, negative_o}, 64'b11);
    run("add_ovcy", 4'd0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    run("sub_ov", 4'd1, 64'h8000000000000000, 64'd1);
    chk("sub_ov_const", {63'd0, overflow_o}, 64'd1);
    run("sub_borrow", 4'd1, 64'd1, 64'd2);
    run("undef", 4'hF, 64'h1234, 64'h5678);
    chk("undef_zero", {63'd0, zero_o}, 64'd1);

    rst_in = 1'b1;
    op_in  = 4'd0;
    A_in   = 64'h10;
    B_in   = 64'h20;
    @(posedge clk_in);
    #1;
    check_outputs("rst_prio", '0);
    rst_in = 1'b0;
    prev = '0;

    for (int i = 0; i < 400; i++) begin
      run("rand", 4'($urandom_range(0, 15)), pick(), pick());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
